stream_net_credit_ctrl: RTL and testbench



---
 rtl/stream_net_pkg.sv | 25 ++
 rtl/stream_net_credit_ctrl_if.sv | 37 +++
 rtl/credit_counter.sv | 56 +++++
 rtl/stream_net_credit_ctrl.sv | 135 +++++++++++++
 tb/tb_stream_net_credit_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_net_pkg.sv
// Shared types and width helpers for the stream network credit controller.
//   inp_state_e : per-input admission state (IDLE, LOCK)
//   sel_width   : bits needed to address NumOut outputs (at least 1)
//   cnt_width   : bits needed to hold 0..MaxCredits
//   idx_width   : bits needed to address NumInp inputs (at least 1)
package stream_net_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } inp_state_e;

    function automatic int unsigned sel_width(input int unsigned num_out);
        return (num_out <= 1) ? 1 : $clog2(num_out);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_credits);
        return $clog2(max_credits + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned num_inp);
        return (num_inp <= 1) ? 1 : $clog2(num_inp);
    endfunction

endpackage

// File: rtl/stream_net_credit_ctrl_if.sv
// Upstream and network-side handshake bundle of the credit controller.
//   inp_valid_i / inp_sel_i / inp_ready_o : upstream stream per input
//   net_valid_o / net_ready_i             : network input handshake
// Signal suffixes are from the controller's point of view; the controller
// uses the slave modport, the upstream/network side the master modport.
interface stream_net_credit_ctrl_if
    import stream_net_pkg::*;
#(
    parameter int unsigned NumInp = 4,
    parameter int unsigned NumOut = 4
) ();

    localparam int unsigned SelWidth = sel_width(NumOut);

    logic [NumInp-1:0]               inp_valid_i;
    logic [NumInp-1:0][SelWidth-1:0] inp_sel_i;
    logic [NumInp-1:0]               inp_ready_o;
    logic [NumInp-1:0]               net_valid_o;
    logic [NumInp-1:0]               net_ready_i;

    modport master (
        output inp_valid_i,
        output inp_sel_i,
        output net_ready_i,
        input  inp_ready_o,
        input  net_valid_o
    );

    modport slave (
        input  inp_valid_i,
        input  inp_sel_i,
        input  net_ready_i,
        output inp_ready_o,
        output net_valid_o
    );

endinterface

// File: rtl/credit_counter.sv
// Credit counter for one network output.
//   clk, rst_n  : clock, asynchronous reset (asserted high)
//   take_i      : one credit reserved by a new grant this cycle
//   give_i      : one credit returned by the downstream buffer this cycle
//   flush_i     : restore the count to MaxCredits next cycle
//   count_o     : current credit count
//   full_err_o  : sticky, a return arrived while the counter was full
module credit_counter
    import stream_net_pkg::*;
#(
    parameter  int unsigned MaxCredits = 4,
    localparam int unsigned CntWidth   = cnt_width(MaxCredits)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                take_i,
    input  logic                give_i,
    input  logic                flush_i,
    output logic [CntWidth-1:0] count_o,
    output logic                full_err_o
);

    localparam logic [CntWidth-1:0] Full = CntWidth'(MaxCredits);

    logic [CntWidth-1:0] count_q, count_d;
    logic                err_q, err_d;
    logic                full, give_eff, take_eff;

    // A return at full cannot correspond to a beat in the buffer: drop it, flag it.
    always_comb begin
        full     = (count_q == Full);
        give_eff = give_i & ~full;
        take_eff = take_i & (count_q != '0);
        err_d    = err_q | (give_i & full);
        count_d  = count_q;
        if (flush_i) begin
            count_d = Full;
        end else begin
            count_d = count_q - CntWidth'(take_eff) + CntWidth'(give_eff);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            count_q <= Full;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o    = count_q;
    assign full_err_o = err_q;

endmodule

// File: rtl/stream_net_credit_ctrl.sv
// Credit-based admission controller in front of a multi-input stream network.
// A beat enters the network only after a credit for its destination output
// has been reserved; inputs contending for one output are served round-robin.
//   clk, rst_n : clock, asynchronous reset (asserted high)
//   flush_i    : restore all credits, release all locks, rewind rr pointer
//   bus        : upstream/network handshakes (slave modport)
//   ret_i      : per-output credit return pulse
//   credit_o   : per-output credit count
//   busy_o     : some input holds a reservation awaiting its handshake
//   err_o      : sticky, a credit was returned to a full counter
module stream_net_credit_ctrl
    import stream_net_pkg::*;
#(
    parameter  int unsigned NumInp     = 4,
    parameter  int unsigned NumOut     = 4,
    parameter  int unsigned MaxCredits = 4,
    localparam int unsigned SelWidth   = sel_width(NumOut),
    localparam int unsigned CntWidth   = cnt_width(MaxCredits),
    localparam int unsigned IdxWidth   = idx_width(NumInp)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush_i,
    stream_net_credit_ctrl_if.slave          bus,
    input  logic [NumOut-1:0]                ret_i,
    output logic [NumOut-1:0][CntWidth-1:0]  credit_o,
    output logic                             busy_o,
    output logic                             err_o
);

    localparam int unsigned SumWidth = IdxWidth + 1;

    inp_state_e          state_q [NumInp];
    inp_state_e          state_d [NumInp];
    logic [IdxWidth-1:0] rr_q, rr_d;

    logic [NumInp-1:0]   grant;
    logic [NumInp-1:0]   lock;
    logic [NumOut-1:0]   take;
    logic [NumOut-1:0]   full_err;
    logic                arb_en;

    // Credit counters, one per network output.
    for (genvar o = 0; o < NumOut; o++) begin : g_cnt
        credit_counter #(
            .MaxCredits (MaxCredits)
        ) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .take_i     (take[o]),
            .give_i     (ret_i[o]),
            .flush_i    (flush_i),
            .count_o    (credit_o[o]),
            .full_err_o (full_err[o])
        );
    end

    always_comb begin
        for (int i = 0; i < NumInp; i++) begin
            lock[i] = (state_q[i] == LOCK);
        end
    end

    // No grants while flushing or in reset.
    assign arb_en = ~flush_i & ~rst_n;

    // Per output: first IDLE, valid input targeting it, scanning from rr_q.
    always_comb begin
        logic                found;
        logic [SumWidth-1:0] sum;
        grant = '0;
        take  = '0;
        found = 1'b0;
        sum   = '0;
        for (int o = 0; o < NumOut; o++) begin
            found = 1'b0;
            for (int k = 0; k < NumInp; k++) begin
                sum = {1'b0, rr_q} + SumWidth'(k);
                if (sum >= SumWidth'(NumInp)) begin
                    sum = sum - SumWidth'(NumInp);
                end
                if (arb_en && (credit_o[o] != '0) && !found &&
                    !lock[sum[IdxWidth-1:0]] &&
                    bus.inp_valid_i[sum[IdxWidth-1:0]] &&
                    (bus.inp_sel_i[sum[IdxWidth-1:0]] == SelWidth'(o))) begin
                    grant[sum[IdxWidth-1:0]] = 1'b1;
                    found                    = 1'b1;
                end
            end
            take[o] = found;
        end
    end

    // Per-input FSM and round-robin pointer next state.
    always_comb begin
        rr_d = rr_q;
        for (int i = 0; i < NumInp; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    if (grant[i] && !bus.net_ready_i[i]) state_d[i] = LOCK;
                LOCK:    if (bus.net_ready_i[i])              state_d[i] = IDLE;
                default:                                      state_d[i] = IDLE;
            endcase
            if (flush_i) begin
                state_d[i] = IDLE;
            end
        end
        if (flush_i) begin
            rr_d = '0;
        end else if (|grant) begin
            rr_d = (rr_q == IdxWidth'(NumInp - 1)) ? '0 : rr_q + IdxWidth'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rr_q <= '0;
            for (int i = 0; i < NumInp; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            rr_q <= rr_d;
            for (int i = 0; i < NumInp; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Zero-latency pass-through for granted or locked inputs.
    assign bus.net_valid_o = bus.inp_valid_i & (grant | lock);
    assign bus.inp_ready_o = bus.net_ready_i & (grant | lock);
    assign busy_o          = |lock;
    assign err_o           = |full_err;

endmodule

// File: tb/tb_stream_net_credit_ctrl.sv
// Self-checking bench for stream_net_credit_ctrl (4 inputs, 4 outputs, 2 credits).
module tb_stream_net_credit_ctrl;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int MC = 2;
    localparam int SW = 2;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic [NI-1:0]         v;
    logic [NI-1:0][SW-1:0] sel;
    logic [NI-1:0]         rdy;
    logic [NO-1:0]         ret;
    logic [NO-1:0][CW-1:0] credit;
    logic                  busy;
    logic                  err;

    int total = 0;
    int bad   = 0;

    // Reference model state: credits, held reservations, rr pointer, error flag.
    int m_cr  [NO];
    bit m_res [NI];
    int m_rr;
    bit m_err;
    int prev_nv;
    int prev_rdy;
    bit prev_free;

    always #5 clk = ~clk;

    stream_net_credit_ctrl_if #(.NumInp(NI), .NumOut(NO)) bus ();

    assign bus.inp_valid_i = v;
    assign bus.inp_sel_i   = sel;
    assign bus.net_ready_i = rdy;

    stream_net_credit_ctrl #(
        .NumInp     (NI),
        .NumOut     (NO),
        .MaxCredits (MC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .bus      (bus),
        .ret_i    (ret),
        .credit_o (credit),
        .busy_o   (busy),
        .err_o    (err)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: model expectations versus DUT every cycle.
    always @(negedge clk) begin
        bit g [NI];
        int exp_nv, exp_ir, exp_busy, idx, take, give;
        if (rst_n) begin
            for (int o = 0; o < NO; o++) chk($sformatf("rst_credit%0d", o), int'(credit[o]), MC);
            chk("rst_net_valid", int'(bus.net_valid_o), 0);
            chk("rst_inp_ready", int'(bus.inp_ready_o), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_err", int'(err), 0);
            for (int o = 0; o < NO; o++) m_cr[o] = MC;
            for (int i = 0; i < NI; i++) m_res[i] = 1'b0;
            m_rr      = 0;
            m_err     = 1'b0;
            prev_free = 1'b1;
        end else begin
            for (int i = 0; i < NI; i++) g[i] = 1'b0;
            for (int o = 0; o < NO; o++) begin
                if (!flush && m_cr[o] > 0) begin
                    for (int k = 0; k < NI; k++) begin
                        idx = (m_rr + k) % NI;
                        if (!m_res[idx] && v[idx] && int'(sel[idx]) == o) begin
                            g[idx] = 1'b1;
                            break;
                        end
                    end
                end
            end
            exp_nv = 0; exp_ir = 0; exp_busy = 0;
            for (int i = 0; i < NI; i++) begin
                if (v[i] && (g[i] || m_res[i])) exp_nv |= (1 << i);
                if (rdy[i] && (g[i] || m_res[i])) exp_ir |= (1 << i);
                if (m_res[i]) exp_busy = 1;
            end
            for (int o = 0; o < NO; o++) chk($sformatf("credit%0d", o), int'(credit[o]), m_cr[o]);
            chk("net_valid", int'(bus.net_valid_o), exp_nv);
            chk("inp_ready", int'(bus.inp_ready_o), exp_ir);
            chk("busy", int'(busy), exp_busy);
            chk("err", int'(err), int'(m_err));
            // valid must hold until handshake unless a flush/reset intervened
            if (!prev_free) begin
                for (int i = 0; i < NI; i++) begin
                    if (prev_nv[i] && !prev_rdy[i])
                        chk($sformatf("valid_stable%0d", i), int'(bus.net_valid_o[i]), 1);
                end
            end
            prev_nv   = int'(bus.net_valid_o);
            prev_rdy  = int'(rdy);
            prev_free = flush;
            for (int o = 0; o < NO; o++) begin
                take = 0;
                for (int i = 0; i < NI; i++) if (g[i] && int'(sel[i]) == o) take = 1;
                give = int'(ret[o]);
                if (give != 0 && m_cr[o] == MC) begin
                    m_err = 1'b1;
                    give  = 0;
                end
                m_cr[o] = flush ? MC : m_cr[o] - take + give;
            end
            for (int i = 0; i < NI; i++) begin
                if (flush)         m_res[i] = 1'b0;
                else if (m_res[i]) m_res[i] = !rdy[i];
                else               m_res[i] = g[i] && !rdy[i];
            end
            if (flush) m_rr = 0;
            else begin
                for (int i = 0; i < NI; i++) if (g[i]) begin
                    m_rr = (m_rr + 1) % NI;
                    break;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NI-1:0] hs;
        rst_n = 1'b1; flush = 1'b0; v = '0; sel = '0; rdy = '0; ret = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_credit1_lit", int'(credit[1]), 2);
        rst_n = 1'b0;
        cyc(); #1;
        chk("idle_credit_all", int'(credit), 8'hAA);
        chk("idle_nv", int'(bus.net_valid_o), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_err", int'(err), 0);

        // Three beats from input 0 to output 1 with two credits.
        cyc(); v = 4'b0001; sel[0] = 2'd1; rdy = 4'b1111; #1;
        chk("t2_b1_nv", int'(bus.net_valid_o), 1); chk("t2_b1_cr", int'(credit[1]), 2);
        cyc(); #1;
        chk("t2_b2_nv", int'(bus.net_valid_o), 1); chk("t2_b2_cr", int'(credit[1]), 1);
        cyc(); ret = 4'b0010; #1;
        chk("t2_stall_nv", int'(bus.net_valid_o), 0); chk("t2_stall_cr", int'(credit[1]), 0);
        cyc(); ret = '0; #1;
        chk("t2_b3_nv", int'(bus.net_valid_o), 1); chk("t2_b3_cr", int'(credit[1]), 1);
        cyc(); v = '0; #1;
        chk("t2_end_cr", int'(credit[1]), 0);
        cyc(); flush = 1'b1;
        cyc(); flush = 1'b0; #1;
        chk("t2_flush_cr", int'(credit[1]), 2);

        // Four inputs contend for output 2.
        cyc(); v = 4'b1111; sel = {2'd2, 2'd2, 2'd2, 2'd2}; #1;
        chk("t3_g0", int'(bus.net_valid_o), 4'b0001);
        cyc(); v = 4'b1110; #1;
        chk("t3_g1", int'(bus.net_valid_o), 4'b0010);
        cyc(); v = 4'b1100; ret = 4'b0100; #1;
        chk("t3_stall", int'(bus.net_valid_o), 0); chk("t3_stall_cr", int'(credit[2]), 0);
        cyc(); #1;
        chk("t3_g2", int'(bus.net_valid_o), 4'b0100); chk("t3_g2_cr", int'(credit[2]), 1);
        cyc(); v = 4'b1000; ret = '0; #1;
        chk("t3_g3", int'(bus.net_valid_o), 4'b1000); chk("t3_g3_cr", int'(credit[2]), 1);
        cyc(); v = '0; #1;
        chk("t3_end_cr", int'(credit[2]), 0);
        cyc(); flush = 1'b1;
        cyc(); flush = 1'b0;

        // Input 1 granted with the network stalled for three cycles.
        cyc(); v = 4'b0010; sel = '0; sel[1] = 2'd3; rdy = '0; #1;
        chk("t4_c1_nv", int'(bus.net_valid_o), 4'b0010); chk("t4_c1_ir", int'(bus.inp_ready_o), 0);
        chk("t4_c1_busy", int'(busy), 0);
        cyc(); #1;
        chk("t4_c2_nv", int'(bus.net_valid_o), 4'b0010); chk("t4_c2_busy", int'(busy), 1);
        chk("t4_c2_cr", int'(credit[3]), 1);
        cyc(); #1;
        chk("t4_c3_nv", int'(bus.net_valid_o), 4'b0010); chk("t4_c3_cr", int'(credit[3]), 1);
        cyc(); rdy = 4'b0010; #1;
        chk("t4_c4_ir", int'(bus.inp_ready_o), 4'b0010);
        cyc(); v = '0; rdy = '0; #1;
        chk("t4_end_busy", int'(busy), 0); chk("t4_end_cr", int'(credit[3]), 1);

        // Grant and return on output 0 in the same cycle; return at full.
        cyc(); v = 4'b0001; sel[0] = 2'd0; rdy = 4'b1111; #1;
        chk("t5_g_cr", int'(credit[0]), 2);
        cyc(); ret = 4'b0001; #1;
        chk("t5_both_nv", int'(bus.net_valid_o), 1); chk("t5_both_cr", int'(credit[0]), 1);
        cyc(); v = '0; #1;
        chk("t5_same_cr", int'(credit[0]), 1);
        cyc(); #1;
        chk("t5_full_cr", int'(credit[0]), 2); chk("t5_full_err0", int'(err), 0);
        cyc(); ret = '0; #1;
        chk("t5_ovf_cr", int'(credit[0]), 2); chk("t5_ovf_err", int'(err), 1);

        // Flush while input 2 holds the last credit of output 3.
        cyc(); v = 4'b0100; sel[2] = 2'd3; rdy = '0; #1;
        chk("t6_g_cr", int'(credit[3]), 1);
        cyc(); flush = 1'b1; #1;
        chk("t6_lock_busy", int'(busy), 1); chk("t6_lock_cr", int'(credit[3]), 0);
        cyc(); flush = 1'b0; v = '0; #1;
        chk("t6_cr", int'(credit), 8'hAA); chk("t6_nv", int'(bus.net_valid_o), 0);
        chk("t6_busy", int'(busy), 0); chk("t6_err", int'(err), 1);

        // Randomized traffic, with one asynchronous reset in the middle.
        hs = '0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (n == 1500) rst_n = 1'b1;
            if (n == 1503) rst_n = 1'b0;
            for (int i = 0; i < NI; i++) begin
                if (!v[i] || hs[i]) begin
                    v[i]   = ($urandom_range(0, 2) != 0);
                    sel[i] = SW'($urandom_range(0, NO - 1));
                end
                rdy[i] = ($urandom_range(0, 3) != 0);
            end
            for (int o = 0; o < NO; o++) begin
                ret[o] = ((m_cr[o] < MC) && ($urandom_range(0, 2) == 0)) ||
                         ($urandom_range(0, 150) == 0);
            end
            flush = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            hs = v & bus.inp_ready_o;
        end
        cyc();
        v = '0; ret = '0; flush = 1'b0;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
